lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the ALU in the RISC-V core. It takes each decoded instruction with the ALU result (effective address or arithmetic result) and rs2 data. Memory ops run through a request/response handshake with data memory, with byte-lane write enables and load extraction/extension. Every instruction then produces one registered writeback record. The LSU stalls upstream while a memory access is outstanding; non-memory ops pass through at one per cycle.

## Interface
- `DWIDTH`, 32: data and address width (only 32 supported).
- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: LSU can accept; low = stall upstream.
- `instruction` in 32: full instruction word.
- `alu_result` in 32: ALU output (byte address for load/store).
- `rs2_data` in 32: store data source.
- `pc_plus4` in 32: link value for JAL/JALR.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_addr` out 32: word address `{alu_result[31:2],2'b00}`.
- `mem_we` out 1: 1 = store, 0 = load.
- `mem_wbe` out 4: byte write enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_resp_valid` in 1: load data valid.
- `mem_rdata` in 32: load data word.
- `wb_valid` out 1: one-cycle pulse per retired instruction.
- `wb_we` out 1: register write enable.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: writeback value.
- `misalign` out 1: misaligned access flag, aligned with `wb_valid`.

## Operation
- States are IDLE, REQ and WAIT. `in_ready` is 1 only in IDLE; acceptance is `in_valid & in_ready`.
- **Non-memory op accepted:**
  - Stay in IDLE.
  - Next cycle: `wb_valid` = 1, `wb_rd` = `instruction[11:7]`.
  - `wb_data` = `pc_plus4` for JAL/JALR, else `alu_result`.
  - `wb_we` = 1 for R, I, LUI, AUIPC, JAL and JALR with rd≠0; 0 for branches.
- **Load or store accepted:**
  - Go to REQ. Address, `mem_wdata` and `mem_wbe` are registered and held stable while `mem_req_valid` = 1.
  - Handshake happens when `mem_req_valid & mem_req_ready`.
- **Store:**
  - On handshake, go to IDLE and pulse `wb_valid` next cycle with `wb_we` = 0.
  - SB: `mem_wdata` = `{4{rs2[7:0]}}`, `mem_wbe` = `4'b0001<<off`.
  - SH: `mem_wdata` = `{2{rs2[15:0]}}`, `mem_wbe` = `4'b0011<<{off[1],1'b0}`.
  - SW: `mem_wdata` = `rs2`, `mem_wbe` = `4'b1111`.
  - `off` = `alu_result[1:0]`.
- **Load:**
  - On handshake, go to WAIT. On `mem_resp_valid` in WAIT, go to IDLE.
  - Next cycle: `wb_valid` = 1, `wb_we` = (rd≠0).
  - LB/LBU: byte `off`, sign- or zero-extended.
  - LH/LHU: half selected by `off[1]`, sign- or zero-extended.
  - LW: full word.
- `mem_resp_valid` outside WAIT is ignored. `mem_wbe` = 0 during loads.
- **Reset:**
  - State goes to IDLE.
  - `mem_req_valid`, `wb_valid`, `wb_we` and `misalign` go to 0.
  - `mem_addr`, `mem_wdata`, `mem_wbe`, `wb_rd` and `wb_data` go to 0.
  - An outstanding access is abandoned; a response arriving after reset is ignored.

## Timing
- Acceptance at cycle 0. Non-memory ops: `wb_valid` at cycle 1; throughput is 1 per cycle.
- Memory ops: `mem_req_valid` is first high at cycle 1. For a handshake at cycle h ≥ 1:
  - store: `wb_valid` and `in_ready` at h+1;
  - load: earliest response at h+1; for a response at r, `wb_valid` and `in_ready` at r+1.
- Minimum load latency is 3 cycles; minimum store latency is 2 cycles.
- The writeback side has no backpressure. `wb_valid` is never high two cycles in a row for memory ops.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - LH/LHU/SH with `off[0]`=1, or LW/SW with `off`≠0, issue no memory request.
  - Stay in IDLE; next cycle `wb_valid` = 1, `wb_we` = 0, `misalign` = 1.
- Undefined:
  - `misalign` is tied to 0.
  - Access proceeds using `off[1]` for halves and ignoring `off` for words.

## Structure
- Load/store funct3 width constants and state encodings go in the shared opcodes header, alongside the existing opcode/funct constants.
- One combinational sub-module, `lsu_load_align`, takes (`mem_rdata`, `off`, `funct3`) and produces the extended word.

## Test plan
- ADDI result 0x0000_1234, rd=5, accepted 3 back-to-back cycles -> `wb_valid` 3 consecutive cycles, `wb_data`=0x1234, `wb_we`=1, `in_ready` stays 1.
- SB rs2=0xAABBCCDD at addr 0x102, `mem_req_ready` delayed 2 cycles -> `mem_wdata`=0xDDDDDDDD, `mem_wbe`=0100, `mem_addr`=0x100 held stable; `wb_valid` with `wb_we`=0 one cycle after handshake.
- LB/LBU from addr 0x103 with `mem_rdata`=0x80FF_0000 -> 0xFFFF_FF80 / 0x0000_0080; LH from 0x102 -> 0xFFFF_80FF.
- JAL rd=1, `pc_plus4`=0x2004 -> `wb_data`=0x2004; BEQ -> `wb_we`=0; rd=0 op -> `wb_we`=0.
- `rst` asserted in WAIT, then `mem_resp_valid` pulsed -> no `wb_valid`, `in_ready`=1 after reset.
- With `LSU_MISALIGN_CHECK_EN`: LW at 0x101 -> no `mem_req_valid`, next cycle `wb_valid`=1, `misalign`=1, `wb_we`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared opcode header for the load/store unit.
// Holds the RV32I major opcodes the LSU decodes, the load/store funct3
// width codes, the LSU state encoding, and small helpers that build the
// store byte-lane enables and replicated store data.
// Macro LSU_MISALIGN_CHECK_EN (consumed in lsu.sv) enables the alignment trap
// that uses access_misaligned() below.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Load/store funct3 width codes (the low two bits give the access size).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  // Byte-lane enables for a store of the given size at the given offset.
  // Halves only look at off[1], so an odd half offset lands on its aligned half.
  function automatic logic [3:0] store_wbe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_wbe = 4'b0001 << off;
      2'b01:   store_wbe = 4'b0011 << {off[1], 1'b0};
      default: store_wbe = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so memory can pick any lane.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] off);
    access_misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half out of a loaded word and
// sign- or zero-extends it according to the load funct3.
// Ports: i_rdata (memory word), i_off (byte offset), i_funct3 (load kind),
//        o_data (extended writeback value).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit downstream of the ALU. Non-memory instructions retire
// one per cycle; loads/stores go through a registered request/response
// handshake with data memory, stalling upstream until they retire. Every
// instruction produces one registered writeback pulse.
// Ports: i_clk/i_rst (sync, active-high); upstream i_in_valid/o_in_ready,
//        i_instruction, i_alu_result, i_rs2_data, i_pc_plus4; memory
//        o_mem_req_valid/i_mem_req_ready, o_mem_addr, o_mem_we, o_mem_wbe,
//        o_mem_wdata, i_mem_resp_valid, i_mem_rdata; writeback o_wb_valid,
//        o_wb_we, o_wb_rd, o_wb_data, o_misalign.
// Macro LSU_MISALIGN_CHECK_EN: when defined, misaligned half/word accesses
// retire immediately with o_misalign set instead of touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_instruction,
  input  logic [DWIDTH-1:0] i_alu_result,
  input  logic [DWIDTH-1:0] i_rs2_data,
  input  logic [DWIDTH-1:0] i_pc_plus4,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [DWIDTH-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_wbe,
  output logic [DWIDTH-1:0] o_mem_wdata,
  input  logic              i_mem_resp_valid,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_we,
  output logic [4:0]        o_wb_rd,
  output logic [DWIDTH-1:0] o_wb_data,
  output logic              o_misalign
);

  lsu_state_e r_state, w_next_state;

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd;
  logic [2:0]        w_funct3;
  logic [1:0]        w_off;
  logic              w_is_load, w_is_store, w_is_mem, w_is_link;
  logic              w_writes_rd, w_accept, w_misaligned, w_unused;
  logic [DWIDTH-1:0] w_load_data;

  logic [DWIDTH-1:0] r_addr, r_wdata, r_wb_data;
  logic [3:0]        r_wbe;
  logic              r_is_store, r_wb_valid, r_wb_we;
  logic [4:0]        r_rd, r_wb_rd;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;

  assign w_opcode   = i_instruction[6:0];
  assign w_rd       = i_instruction[11:7];
  assign w_funct3   = i_instruction[14:12];
  assign w_off      = i_alu_result[1:0];
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_is_link  = (w_opcode == OPC_JAL) | (w_opcode == OPC_JALR);
  assign w_accept   = i_in_valid & (r_state == ST_IDLE);
  assign w_unused   = ^i_instruction[31:15];

  // Only register-producing formats write rd; branches, loads/stores and
  // anything unrecognised never write here.
  assign w_writes_rd = (w_rd != 5'd0) &&
                       ((w_opcode == OPC_OP)  || (w_opcode == OPC_OPIMM) ||
                        (w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) || w_is_link);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misaligned = w_is_mem & access_misaligned(w_funct3[1:0], w_off);
`else
  assign w_misaligned = 1'b0;
`endif

  lsu_load_align u_load_align (
    .i_rdata  (i_mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state plus the two state-decoded handshake outputs.
  always_comb begin
    w_next_state    = r_state;
    o_in_ready      = 1'b0;
    o_mem_req_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (w_accept && w_is_mem && !w_misaligned) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) w_next_state = r_is_store ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mem_resp_valid) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request fields are captured at acceptance and held for the whole REQ
  // phase; the writeback record is a single-cycle pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wbe      <= 4'b0000;
      r_is_store <= 1'b0;
      r_rd       <= 5'd0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_mem && !w_misaligned) begin
              r_addr     <= {i_alu_result[DWIDTH-1:2], 2'b00};
              r_wdata    <= store_wdata(w_funct3[1:0], i_rs2_data);
              r_wbe      <= w_is_store ? store_wbe(w_funct3[1:0], w_off) : 4'b0000;
              r_is_store <= w_is_store;
              r_rd       <= w_rd;
              r_funct3   <= w_funct3;
              r_off      <= w_off;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_we    <= w_writes_rd;
              r_wb_rd    <= w_rd;
              r_wb_data  <= w_is_link ? i_pc_plus4 : i_alu_result;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_req_ready && r_is_store) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
          end
        end
        ST_WAIT: begin
          if (i_mem_resp_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= (r_rd != 5'd0);
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_misalign <= 1'b0;
    else       r_misalign <= w_accept & w_misaligned;
  end
  assign o_misalign = r_misalign;
`else
  assign o_misalign = 1'b0;
`endif

  assign o_mem_addr  = r_addr;
  assign o_mem_we    = r_is_store;
  assign o_mem_wbe   = r_wbe;
  assign o_mem_wdata = r_wdata;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_we     = r_wb_we;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. A transaction-level model predicts,
// for every cycle, in_ready, the memory request fields and the writeback
// record; a compare process checks the DUT against it on each negedge.
// Directed cases pin the model with hand-computed values, then a randomized
// instruction stream with random memory delays runs. Honours
// LSU_MISALIGN_CHECK_EN when the design is built with it.
module tb_lsu;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic        i_clk;
  logic        i_rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_instruction;
  logic [31:0] i_alu_result;
  logic [31:0] i_rs2_data;
  logic [31:0] i_pc_plus4;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_wbe;
  logic [31:0] o_mem_wdata;
  logic        i_mem_resp_valid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic        o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_misalign;

  lsu #(.DWIDTH(32)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .i_instruction    (i_instruction),
    .i_alu_result     (i_alu_result),
    .i_rs2_data       (i_rs2_data),
    .i_pc_plus4       (i_pc_plus4),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_addr       (o_mem_addr),
    .o_mem_we         (o_mem_we),
    .o_mem_wbe        (o_mem_wbe),
    .o_mem_wdata      (o_mem_wdata),
    .i_mem_resp_valid (i_mem_resp_valid),
    .i_mem_rdata      (i_mem_rdata),
    .o_wb_valid       (o_wb_valid),
    .o_wb_we          (o_wb_we),
    .o_wb_rd          (o_wb_rd),
    .o_wb_data        (o_wb_data),
    .o_misalign       (o_misalign)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  // Model expectations for the outputs visible in the current cycle.
  logic        expInReady, expReq, expStore, expWbValid, expWbWe, expMisalign;
  logic        expChkRd, expChkData;
  logic [31:0] expAddr, expWdata, expWbData;
  logic [3:0]  expWbe;
  logic [4:0]  expWbRd;
  logic [31:0] lastReqAddr, lastReqWdata;
  logic [3:0]  lastReqWbe;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Spec-level model helpers.
  function automatic logic modelWritesRd(input logic [6:0] opc, input logic [4:0] rd);
    if (rd == 5'd0) return 1'b0;
    return (opc == OP_OP) || (opc == OP_OPIMM) || (opc == OP_LUI) ||
           (opc == OP_AUIPC) || (opc == OP_JAL) || (opc == OP_JALR);
  endfunction

  function automatic logic [3:0] modelWbe(input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] t;
    case (f3)
      3'b000:  t = 32'd1 << off;
      3'b001:  t = 32'd3 << (off & 2'b10);
      default: t = 32'd15;
    endcase
    return t[3:0];
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      3'b000:  return (rs2 & 32'hFF) * 32'h01010101;
      3'b001:  return (rs2 & 32'hFFFF) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (rdata >> (16 * off[1])) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic modelMisaligned(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'b001 || f3 == 3'b101) return off[0];
    if (f3 == 3'b010) return off != 2'b00;
    return 1'b0;
  endfunction
`endif

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (armed) begin
      checkOutput("inReady", 32'(o_in_ready), 32'(expInReady));
      checkOutput("memReqValid", 32'(o_mem_req_valid), 32'(expReq));
      checkOutput("wbValid", 32'(o_wb_valid), 32'(expWbValid));
      checkOutput("misalign", 32'(o_misalign), 32'(expMisalign));
      if (expReq) begin
        checkOutput("memAddr", o_mem_addr, expAddr);
        checkOutput("memWe", 32'(o_mem_we), 32'(expStore));
        checkOutput("memWbe", 32'(o_mem_wbe), 32'(expWbe));
        if (expStore) checkOutput("memWdata", o_mem_wdata, expWdata);
      end
      if (expWbValid) begin
        checkOutput("wbWe", 32'(o_wb_we), 32'(expWbWe));
        if (expChkRd)   checkOutput("wbRd", 32'(o_wb_rd), 32'(expWbRd));
        if (expChkData) checkOutput("wbData", o_wb_data, expWbData);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    expWbValid  = 1'b0;
    expWbWe     = 1'b0;
    expMisalign = 1'b0;
    expChkRd    = 1'b0;
    expChkData  = 1'b0;
  endtask

  task automatic driveJunk();
    i_in_valid    = 1'($urandom_range(0, 1));
    i_instruction = $urandom;
  endtask

  task automatic idleCycle();
    i_in_valid = 1'b0;
    i_instruction = $urandom;
    step();
  endtask

  // Issues one instruction and walks it to retirement, updating the model.
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                               input int rdyDelay, input int rspDelay, input logic [31:0] rdata);
    logic isMem, isStore, mis;
    isStore = (opc == OP_STORE);
    isMem   = isStore || (opc == OP_LOAD);
    mis     = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (isMem) mis = modelMisaligned(f3, alu[1:0]);
`endif
    i_instruction = {17'($urandom), f3, rd, opc};
    i_alu_result  = alu;
    i_rs2_data    = rs2;
    i_pc_plus4    = pc4;
    i_in_valid    = 1'b1;
    step();
    if (!isMem || mis) begin
      expWbValid  = 1'b1;
      expWbWe     = mis ? 1'b0 : modelWritesRd(opc, rd);
      expWbRd     = rd;
      expChkRd    = !mis;
      expWbData   = (opc == OP_JAL || opc == OP_JALR) ? pc4 : alu;
      expChkData  = !mis;
      expMisalign = mis;
      expInReady  = 1'b1;
      expReq      = 1'b0;
    end else begin
      expInReady = 1'b0;
      expReq     = 1'b1;
      expStore   = isStore;
      expAddr    = alu & 32'hFFFF_FFFC;
      expWbe     = isStore ? modelWbe(f3, alu[1:0]) : 4'b0000;
      expWdata   = modelWdata(f3, rs2);
      for (int k = 0; k < rdyDelay; k++) begin
        driveJunk();
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'($urandom_range(0, 1));
        i_mem_rdata      = $urandom;
        step();
      end
      driveJunk();
      i_mem_resp_valid = 1'($urandom_range(0, 1));
      i_mem_req_ready  = 1'b1;
      lastReqAddr  = o_mem_addr;
      lastReqWbe   = o_mem_wbe;
      lastReqWdata = o_mem_wdata;
      step();
      i_mem_req_ready  = 1'b0;
      i_mem_resp_valid = 1'b0;
      expReq = 1'b0;
      if (isStore) begin
        expWbValid = 1'b1;
        expWbWe    = 1'b0;
        expInReady = 1'b1;
      end else begin
        for (int k = 0; k < rspDelay; k++) begin
          driveJunk();
          i_mem_req_ready = 1'($urandom_range(0, 1));
          i_mem_rdata     = $urandom;
          step();
        end
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = rdata;
        step();
        i_mem_resp_valid = 1'b0;
        expWbValid = 1'b1;
        expWbWe    = (rd != 5'd0);
        expWbRd    = rd;
        expChkRd   = 1'b1;
        expWbData  = modelLoad(rdata, alu[1:0], f3);
        expChkData = 1'b1;
        expInReady = 1'b1;
      end
    end
    i_in_valid      = 1'b0;
    i_mem_req_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] opcs [10];
    logic [2:0] lf3 [5];
    logic [6:0] opc;
    logic [2:0] f3;
    opcs = '{OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_LOAD, OP_STORE};
    lf3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    i_rst = 1'b1; i_in_valid = 1'b0; i_instruction = '0; i_alu_result = '0;
    i_rs2_data = '0; i_pc_plus4 = '0; i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b0; i_mem_rdata = '0;
    expInReady = 1'b1; expReq = 1'b0; expStore = 1'b0; expAddr = '0; expWbe = '0;
    expWdata = '0; expWbRd = '0; expWbData = '0;
    step();
    step();
    armed = 1'b1;
    checkOutput("resetWbValid", 32'(o_wb_valid), 32'd0);
    checkOutput("resetReqValid", 32'(o_mem_req_valid), 32'd0);
    checkOutput("resetInReady", 32'(o_in_ready), 32'd1);
    checkOutput("resetAddr", o_mem_addr, 32'd0);
    checkOutput("resetWbData", o_wb_data, 32'd0);
    i_rst = 1'b0;
    idleCycle();

    // ADDI back-to-back: three writebacks on consecutive cycles.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(OP_OPIMM, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 32'h0);
      checkOutput("addiWbValid", 32'(o_wb_valid), 32'd1);
      checkOutput("addiWbData", o_wb_data, 32'h0000_1234);
      checkOutput("addiWbWe", 32'(o_wb_we), 32'd1);
      checkOutput("addiInReady", 32'(o_in_ready), 32'd1);
    end

    // SB with ready held off two cycles.
    applyStimulus(OP_STORE, 3'b000, 5'd0, 32'h0000_0102, 32'hAABB_CCDD, 32'h0, 2, 0, 32'h0);
    checkOutput("sbAddr", lastReqAddr, 32'h0000_0100);
    checkOutput("sbWbe", 32'(lastReqWbe), 32'h4);
    checkOutput("sbWdata", lastReqWdata, 32'hDDDD_DDDD);
    checkOutput("sbWbValid", 32'(o_wb_valid), 32'd1);
    checkOutput("sbWbWe", 32'(o_wb_we), 32'd0);

    // Load extraction and extension.
    applyStimulus(OP_LOAD, 3'b000, 5'd6, 32'h0000_0103, 32'h0, 32'h0, 0, 0, 32'h80FF_0000);
    checkOutput("lbData", o_wb_data, 32'hFFFF_FF80);
    applyStimulus(OP_LOAD, 3'b100, 5'd6, 32'h0000_0103, 32'h0, 32'h0, 1, 2, 32'h80FF_0000);
    checkOutput("lbuData", o_wb_data, 32'h0000_0080);
    applyStimulus(OP_LOAD, 3'b001, 5'd6, 32'h0000_0102, 32'h0, 32'h0, 0, 1, 32'h80FF_0000);
    checkOutput("lhData", o_wb_data, 32'hFFFF_80FF);

    // Link value, branch and rd=0.
    applyStimulus(OP_JAL, 3'b000, 5'd1, 32'h0000_0040, 32'h0, 32'h0000_2004, 0, 0, 32'h0);
    checkOutput("jalData", o_wb_data, 32'h0000_2004);
    checkOutput("jalWe", 32'(o_wb_we), 32'd1);
    applyStimulus(OP_BRANCH, 3'b000, 5'd3, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("beqWe", 32'(o_wb_we), 32'd0);
    applyStimulus(OP_OPIMM, 3'b000, 5'd0, 32'h0000_0077, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("rd0We", 32'(o_wb_we), 32'd0);

`ifdef LSU_MISALIGN_CHECK_EN
    applyStimulus(OP_LOAD, 3'b010, 5'd9, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("misLwReq", 32'(o_mem_req_valid), 32'd0);
    checkOutput("misLwWbValid", 32'(o_wb_valid), 32'd1);
    checkOutput("misLwFlag", 32'(o_misalign), 32'd1);
    checkOutput("misLwWe", 32'(o_wb_we), 32'd0);
`endif

    // Randomized instruction stream with random memory delays.
    for (int n = 0; n < 400; n++) begin
      opc = opcs[$urandom_range(0, 9)];
      if (opc == OP_LOAD)       f3 = lf3[$urandom_range(0, 4)];
      else if (opc == OP_STORE) f3 = 3'($urandom_range(0, 2));
      else                      f3 = 3'($urandom_range(0, 7));
      applyStimulus(opc, f3, 5'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) idleCycle();
    end

    // Reset while a load waits for its response; the late response is dropped.
    applyStimulus(OP_STORE, 3'b010, 5'd0, 32'h0000_0208, 32'h1234_5678, 32'h0, 0, 0, 32'h0);
    i_instruction = {17'd0, 3'b010, 5'd7, OP_LOAD};
    i_alu_result  = 32'h0000_0200;
    i_in_valid    = 1'b1;
    step();
    expInReady = 1'b0; expReq = 1'b1; expStore = 1'b0; expAddr = 32'h0000_0200; expWbe = 4'b0000;
    i_in_valid = 1'b0;
    i_mem_req_ready = 1'b1;
    step();
    expReq = 1'b0;
    i_mem_req_ready = 1'b0;
    i_rst = 1'b1;
    step();
    expInReady = 1'b1;
    checkOutput("rstAddr", o_mem_addr, 32'd0);
    checkOutput("rstWdata", o_mem_wdata, 32'd0);
    checkOutput("rstWbe", 32'(o_mem_wbe), 32'd0);
    checkOutput("rstWbRd", 32'(o_wb_rd), 32'd0);
    checkOutput("rstWbWe", 32'(o_wb_we), 32'd0);
    i_rst = 1'b0;
    i_mem_resp_valid = 1'b1;
    i_mem_rdata = 32'hDEAD_BEEF;
    step();
    i_mem_resp_valid = 1'b0;
    checkOutput("lateRespWbValid", 32'(o_wb_valid), 32'd0);
    checkOutput("lateRespInReady", 32'(o_in_ready), 32'd1);
    idleCycle();
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
